// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM side of the CPU: RAM word, RAM handshake
// state and the RAM arbiter's transfer state.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Status reported by the RAM model each cycle; only ACCESS completes a word.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter transfer state: arbitrating, data burst, or single fetch word.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DXFER = 2'd1,
    IXFER = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of per-core cache request lines and the single RAM port.
// The arbiter takes the slave view; the caches and RAM model sit on master.
interface ram_arbiter_if #(
  parameter int CPUS = 2
);
  import cpu_types_pkg::*;

  // Per-core cache side
  logic [CPUS-1:0]  iREN;
  word_t [CPUS-1:0] iaddr;
  logic [CPUS-1:0]  dREN;
  logic [CPUS-1:0]  dWEN;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  logic [CPUS-1:0]  iwait;
  logic [CPUS-1:0]  dwait;
  word_t [CPUS-1:0] iload;
  word_t [CPUS-1:0] dload;

  // Shared RAM port
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first requester strictly
// after the last-granted index, wrapping around, so the last winner has the
// lowest priority.
module rr_pick #(
  parameter int  N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan N candidates starting one past the pointer; keep the first hit.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!valid && req[IW'((int'(last) + k) % N)]) begin
        valid = 1'b1;
        idx   = IW'((int'(last) + k) % N);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between the instruction and data caches of
// CPUS cores. Data requests beat fetches; each class is round-robin across
// cores. A grant is locked for a whole transfer (BURST words for data, one
// for a fetch) and the RAM lines are driven combinationally from that grant.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int  CPUS  = 2,
  parameter int  BURST = 2,
  localparam int IW    = $clog2(CPUS)
) (
  input  logic          CLK,
  input  logic          nRST,
  ram_arbiter_if.slave  bus,
  output logic [IW-1:0] gnt_cpu,
  output logic          busy
);

  localparam int CW = $clog2(BURST) + 1;

  arb_state_t      state;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   dptr;
  logic [IW-1:0]   iptr;
  logic            op_write;
  logic [CW-1:0]   cnt;

  logic [CPUS-1:0] dreq;
  logic            d_valid;
  logic            i_valid;
  logic [IW-1:0]   d_idx;
  logic [IW-1:0]   i_idx;
  logic            d_held;
  logic            i_held;
  logic            access;

  rr_pick #(.N(CPUS)) u_dpick (
    .req   (dreq),
    .last  (dptr),
    .valid (d_valid),
    .idx   (d_idx)
  );

  rr_pick #(.N(CPUS)) u_ipick (
    .req   (bus.iREN),
    .last  (iptr),
    .valid (i_valid),
    .idx   (i_idx)
  );

  // Arbitrate in IDLE, then count acknowledged words until done or aborted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      gnt      <= '0;
      dptr     <= IW'(CPUS - 1);
      iptr     <= IW'(CPUS - 1);
      op_write <= 1'b0;
      cnt      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      unique case (state)
        IDLE: begin
          if (d_valid) begin
            state    <= DXFER;
            gnt      <= d_idx;
            dptr     <= d_idx;
            op_write <= bus.dWEN[d_idx];
          end else if (i_valid) begin
            state    <= IXFER;
            gnt      <= i_idx;
            iptr     <= i_idx;
            op_write <= 1'b0;
          end
        end
        DXFER: begin
          if (!d_held) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (access) begin
            if (cnt == CW'(BURST - 1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        IXFER: begin
          if (!i_held || access) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Steer the locked requester onto the RAM port and ack it on ACCESS.
  always_comb begin
    dreq   = bus.dREN | bus.dWEN;
    d_held = (state == DXFER) && dreq[gnt];
    i_held = (state == IXFER) && bus.iREN[gnt];
    access = (bus.ramstate == ACCESS);

    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    gnt_cpu      = gnt;
    busy         = (state != IDLE);

    if (d_held) begin
      bus.ramWEN     = op_write;
      bus.ramREN     = !op_write;
      bus.ramaddr    = bus.daddr[gnt];
      bus.ramstore   = bus.dstore[gnt];
      bus.dload[gnt] = bus.ramload;
      if (access) bus.dwait[gnt] = 1'b0;
    end

    if (i_held) begin
      bus.ramREN     = 1'b1;
      bus.ramaddr    = bus.iaddr[gnt];
      bus.iload[gnt] = bus.ramload;
      if (access) bus.iwait[gnt] = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by a
// randomized run against a transaction-level reference model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS  = 2;
  localparam int BURST = 2;
  localparam int IW    = $clog2(CPUS);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] gnt_cpu;
  logic          busy;

  int checks = 0;
  int errors = 0;

  ram_arbiter_if #(.CPUS(CPUS)) bus ();

  ram_arbiter #(.CPUS(CPUS), .BURST(BURST)) dut (
    .CLK     (clk),
    .nRST    (rst_n),
    .bus     (bus.slave),
    .gnt_cpu (gnt_cpu),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.iREN     = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.iaddr    = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    bus.dREN     = '1;
    bus.iREN     = '1;
    bus.daddr[0] = 32'h123;
    bus.ramstate = ACCESS;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL reset_ramREN: got %0b want 0", bus.ramREN); end
    checks++; if (bus.ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ramWEN: got %0b want 0", bus.ramWEN); end
    checks++; if (bus.iwait !== 2'b11) begin errors++; $display("FAIL reset_iwait: got %b want 11", bus.iwait); end
    checks++; if (bus.dwait !== 2'b11) begin errors++; $display("FAIL reset_dwait: got %b want 11", bus.dwait); end
    checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("FAIL reset_ramaddr: got %h want 0", bus.ramaddr); end
    checks++; if (bus.ramstore !== 32'h0) begin errors++; $display("FAIL reset_ramstore: got %h want 0", bus.ramstore); end
    checks++; if (gnt_cpu !== '0) begin errors++; $display("FAIL reset_gnt: got %0d want 0", gnt_cpu); end
    checks++; if (bus.iload !== '0) begin errors++; $display("FAIL reset_iload: got %h want 0", bus.iload); end
    checks++; if (bus.dload !== '0) begin errors++; $display("FAIL reset_dload: got %h want 0", bus.dload); end
  endtask

  task automatic test_fetch();
    do_reset();
    next_cycle();
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h40;
    bus.ramstate = ACCESS;
    bus.ramload  = $urandom;
    @(negedge clk);
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL fetch_c0_ren: got %0b want 0", bus.ramREN); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL fetch_c1_ren: got %0b want 1", bus.ramREN); end
    checks++; if (bus.ramaddr !== 32'h40) begin errors++; $display("FAIL fetch_c1_addr: got %h want 40", bus.ramaddr); end
    checks++; if (bus.iwait !== 2'b10) begin errors++; $display("FAIL fetch_c1_iwait: got %b want 10", bus.iwait); end
    checks++; if (bus.iload[0] !== bus.ramload) begin errors++; $display("FAIL fetch_c1_iload0: got %h want %h", bus.iload[0], bus.ramload); end
    checks++; if (bus.iload[1] !== 32'h0) begin errors++; $display("FAIL fetch_c1_iload1: got %h want 0", bus.iload[1]); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fetch_c1_busy: got %0b want 1", busy); end
    next_cycle();
    bus.iREN[0] = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_c2_busy: got %0b want 0", busy); end
    checks++; if (bus.iwait !== 2'b11) begin errors++; $display("FAIL fetch_c2_iwait: got %b want 11", bus.iwait); end
  endtask

  task automatic test_data_priority();
    do_reset();
    next_cycle();
    bus.dREN[1]  = 1'b1;
    bus.daddr[1] = 32'h80;
    bus.iREN[0]  = 1'b1;
    bus.iaddr[0] = 32'h100;
    bus.ramstate = ACCESS;
    bus.ramload  = $urandom;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_c0_busy: got %0b want 0", busy); end
    for (int w = 0; w < 2; w++) begin
      next_cycle();
      bus.daddr[1] = 32'h80 + 32'(4 * w);
      @(negedge clk);
      checks++; if (gnt_cpu !== IW'(1)) begin errors++; $display("FAIL prio_gnt w%0d: got %0d want 1", w, gnt_cpu); end
      checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL prio_ren w%0d: got %0b want 1", w, bus.ramREN); end
      checks++; if (bus.ramaddr !== 32'h80 + 32'(4 * w)) begin errors++; $display("FAIL prio_addr w%0d: got %h want %h", w, bus.ramaddr, 32'h80 + 32'(4 * w)); end
      checks++; if (bus.dwait !== 2'b01) begin errors++; $display("FAIL prio_dwait w%0d: got %b want 01", w, bus.dwait); end
      checks++; if (bus.iwait !== 2'b11) begin errors++; $display("FAIL prio_iwait w%0d: got %b want 11", w, bus.iwait); end
      checks++; if (bus.dload[1] !== bus.ramload) begin errors++; $display("FAIL prio_dload w%0d: got %h want %h", w, bus.dload[1], bus.ramload); end
    end
    next_cycle();
    bus.dREN[1] = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prio_bubble_busy: got %0b want 0", busy); end
    checks++; if (bus.iwait !== 2'b11) begin errors++; $display("FAIL prio_bubble_iwait: got %b want 11", bus.iwait); end
    next_cycle();
    @(negedge clk);
    checks++; if (gnt_cpu !== IW'(0)) begin errors++; $display("FAIL prio_fetch_gnt: got %0d want 0", gnt_cpu); end
    checks++; if (bus.ramaddr !== 32'h100) begin errors++; $display("FAIL prio_fetch_addr: got %h want 100", bus.ramaddr); end
    checks++; if (bus.iwait !== 2'b10) begin errors++; $display("FAIL prio_fetch_iwait: got %b want 10", bus.iwait); end
    next_cycle();
    bus.iREN[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_dwait;
    int         g;
    do_reset();
    next_cycle();
    bus.dWEN      = 2'b11;
    bus.daddr[0]  = 32'h1000;
    bus.daddr[1]  = 32'h2000;
    bus.dstore[0] = $urandom;
    bus.dstore[1] = $urandom;
    bus.ramstate  = ACCESS;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      @(negedge clk);
      if (c % 3 == 0) begin
        checks++; if (bus.ramWEN !== 1'b0) begin errors++; $display("FAIL b2b_bubble_wen c%0d: got %0b want 0", c, bus.ramWEN); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_bubble_busy c%0d: got %0b want 0", c, busy); end
      end else begin
        g = (c / 3) % 2;
        exp_dwait    = 2'b11;
        exp_dwait[g] = 1'b0;
        checks++; if (gnt_cpu !== IW'(g)) begin errors++; $display("FAIL b2b_gnt c%0d: got %0d want %0d", c, gnt_cpu, g); end
        checks++; if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin errors++; $display("FAIL b2b_en c%0d: got wen=%0b ren=%0b want 1/0", c, bus.ramWEN, bus.ramREN); end
        checks++; if (bus.ramstore !== bus.dstore[g]) begin errors++; $display("FAIL b2b_store c%0d: got %h want %h", c, bus.ramstore, bus.dstore[g]); end
        checks++; if (bus.dwait !== exp_dwait) begin errors++; $display("FAIL b2b_dwait c%0d: got %b want %b", c, bus.dwait, exp_dwait); end
      end
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_write_priority();
    do_reset();
    next_cycle();
    bus.dWEN[0]  = 1'b1;
    bus.dREN[0]  = 1'b1;
    bus.ramstate = ACCESS;
    @(negedge clk);
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL wr_c0_ren: got %0b want 0", bus.ramREN); end
    for (int w = 0; w < 2; w++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (bus.ramWEN !== 1'b1) begin errors++; $display("FAIL wr_wen w%0d: got %0b want 1", w, bus.ramWEN); end
      checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL wr_ren w%0d: got %0b want 0", w, bus.ramREN); end
      checks++; if (bus.dwait !== 2'b10) begin errors++; $display("FAIL wr_dwait w%0d: got %b want 10", w, bus.dwait); end
    end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_end_busy: got %0b want 0", busy); end
  endtask

  task automatic test_busy_stall();
    ramstate_t seq [3];
    seq = '{BUSY, ERROR, BUSY};
    do_reset();
    next_cycle();
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h200;
    bus.ramstate = BUSY;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_c0_busy: got %0b want 0", busy); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.ramstate = seq[i];
      @(negedge clk);
      checks++; if (bus.dwait !== 2'b11) begin errors++; $display("FAIL stall_dwait c%0d: got %b want 11", i + 1, bus.dwait); end
      checks++; if (bus.ramaddr !== 32'h200) begin errors++; $display("FAIL stall_addr c%0d: got %h want 200", i + 1, bus.ramaddr); end
      checks++; if (bus.ramREN !== 1'b1) begin errors++; $display("FAIL stall_ren c%0d: got %0b want 1", i + 1, bus.ramREN); end
    end
    next_cycle();
    bus.ramstate = ACCESS;
    @(negedge clk);
    checks++; if (bus.dwait !== 2'b10) begin errors++; $display("FAIL stall_ack1: got %b want 10", bus.dwait); end
    checks++; if (bus.ramaddr !== 32'h200) begin errors++; $display("FAIL stall_ack1_addr: got %h want 200", bus.ramaddr); end
    next_cycle();
    bus.daddr[0] = 32'h204;
    @(negedge clk);
    checks++; if (bus.dwait !== 2'b10) begin errors++; $display("FAIL stall_ack2: got %b want 10", bus.dwait); end
    checks++; if (bus.ramaddr !== 32'h204) begin errors++; $display("FAIL stall_ack2_addr: got %h want 204", bus.ramaddr); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_end_busy: got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    next_cycle();
    bus.dREN[0]  = 1'b1;
    bus.daddr[0] = 32'h300;
    bus.ramstate = ACCESS;
    next_cycle();
    @(negedge clk);
    checks++; if (bus.dwait !== 2'b10) begin errors++; $display("FAIL rmid_first_ack: got %b want 10", bus.dwait); end
    next_cycle();
    bus.daddr[0] = 32'h304;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %0b want 0", busy); end
    checks++; if (bus.ramREN !== 1'b0) begin errors++; $display("FAIL rmid_ren: got %0b want 0", bus.ramREN); end
    checks++; if (bus.iwait !== 2'b11 || bus.dwait !== 2'b11) begin errors++; $display("FAIL rmid_waits: got i=%b d=%b want 11/11", bus.iwait, bus.dwait); end
    checks++; if (bus.ramaddr !== 32'h0) begin errors++; $display("FAIL rmid_addr: got %h want 0", bus.ramaddr); end
    checks++; if (gnt_cpu !== '0) begin errors++; $display("FAIL rmid_gnt: got %0d want 0", gnt_cpu); end
    bus.dREN = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt_cpu !== IW'(0)) begin errors++; $display("FAIL rmid_rearb_gnt: got %0d want 0", gnt_cpu); end
    checks++; if (bus.dwait !== 2'b10) begin errors++; $display("FAIL rmid_rearb_dwait: got %b want 10", bus.dwait); end
    next_cycle();
    clear_inputs();
  endtask

  // Pick the first requester after 'last', wrapping around.
  function automatic int pick(logic [CPUS-1:0] req, int last);
    for (int k = 1; k <= CPUS; k++) begin
      if (req[(last + k) % CPUS]) return (last + k) % CPUS;
    end
    return -1;
  endfunction

  task automatic test_random();
    // Reference model: one locked transfer at a time, tracked as words completed.
    bit              m_active, m_data, m_write;
    int              m_core, m_done, m_dlast, m_ilast;
    // Requester agents.
    bit              d_on [CPUS];
    bit              i_on [CPUS];
    bit              d_ack [CPUS];
    bit              i_ack [CPUS];
    int              d_left [CPUS];
    int              d_op [CPUS];
    // Per-cycle expectations.
    bit              held, acc;
    logic            e_ren, e_wen;
    word_t           e_addr, e_store;
    logic [CPUS-1:0] e_dwait, e_iwait;
    word_t [CPUS-1:0] e_dload, e_iload;
    int              sel, r;

    do_reset();
    m_active = 1'b0; m_data = 1'b0; m_write = 1'b0;
    m_core = 0; m_done = 0; m_dlast = CPUS - 1; m_ilast = CPUS - 1;
    for (int c = 0; c < CPUS; c++) begin
      d_on[c] = 1'b0; i_on[c] = 1'b0; d_ack[c] = 1'b0; i_ack[c] = 1'b0;
      d_left[c] = 0; d_op[c] = 0;
    end

    for (int cyc = 0; cyc < 2000; cyc++) begin
      next_cycle();
      for (int c = 0; c < CPUS; c++) begin
        if (d_on[c]) begin
          if (d_ack[c]) begin
            d_left[c]     = d_left[c] - 1;
            bus.daddr[c]  = bus.daddr[c] + 32'd4;
            bus.dstore[c] = $urandom;
            if (d_left[c] == 0) d_on[c] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            d_on[c] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          d_on[c]       = 1'b1;
          d_left[c]     = BURST;
          d_op[c]       = int'($urandom_range(0, 2));
          bus.daddr[c]  = $urandom & 32'hFFFF_FFFC;
          bus.dstore[c] = $urandom;
        end
        bus.dREN[c] = d_on[c] && (d_op[c] != 1);
        bus.dWEN[c] = d_on[c] && (d_op[c] != 0);

        if (i_on[c]) begin
          if (i_ack[c] || $urandom_range(0, 39) == 0) i_on[c] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          i_on[c]      = 1'b1;
          bus.iaddr[c] = $urandom & 32'hFFFF_FFFC;
        end
        bus.iREN[c] = i_on[c];
      end
      r = int'($urandom_range(0, 9));
      bus.ramstate = (r < 6) ? ACCESS : (r < 8) ? BUSY : (r < 9) ? ERROR : FREE;
      bus.ramload  = $urandom;

      @(negedge clk);
      held = m_active && (m_data ? (bus.dREN[m_core] || bus.dWEN[m_core]) : bus.iREN[m_core]);
      acc  = held && (bus.ramstate == ACCESS);
      e_ren   = held && !(m_data && m_write);
      e_wen   = held && m_data && m_write;
      e_addr  = !held ? 32'h0 : (m_data ? bus.daddr[m_core] : bus.iaddr[m_core]);
      e_store = (held && m_data) ? bus.dstore[m_core] : 32'h0;
      e_dwait = '1; e_iwait = '1; e_dload = '0; e_iload = '0;
      if (held && m_data) begin
        e_dload[m_core] = bus.ramload;
        if (acc) e_dwait[m_core] = 1'b0;
      end
      if (held && !m_data) begin
        e_iload[m_core] = bus.ramload;
        if (acc) e_iwait[m_core] = 1'b0;
      end

      checks++; if (busy !== m_active) begin errors++; $display("FAIL rnd_busy cyc%0d: got %0b want %0b", cyc, busy, m_active); end
      checks++; if (gnt_cpu !== IW'(m_core)) begin errors++; $display("FAIL rnd_gnt cyc%0d: got %0d want %0d", cyc, gnt_cpu, m_core); end
      checks++; if (bus.ramREN !== e_ren) begin errors++; $display("FAIL rnd_ren cyc%0d: got %0b want %0b", cyc, bus.ramREN, e_ren); end
      checks++; if (bus.ramWEN !== e_wen) begin errors++; $display("FAIL rnd_wen cyc%0d: got %0b want %0b", cyc, bus.ramWEN, e_wen); end
      checks++; if (bus.ramaddr !== e_addr) begin errors++; $display("FAIL rnd_addr cyc%0d: got %h want %h", cyc, bus.ramaddr, e_addr); end
      checks++; if (bus.ramstore !== e_store) begin errors++; $display("FAIL rnd_store cyc%0d: got %h want %h", cyc, bus.ramstore, e_store); end
      checks++; if (bus.dwait !== e_dwait) begin errors++; $display("FAIL rnd_dwait cyc%0d: got %b want %b", cyc, bus.dwait, e_dwait); end
      checks++; if (bus.iwait !== e_iwait) begin errors++; $display("FAIL rnd_iwait cyc%0d: got %b want %b", cyc, bus.iwait, e_iwait); end
      checks++; if (bus.dload !== e_dload) begin errors++; $display("FAIL rnd_dload cyc%0d: got %h want %h", cyc, bus.dload, e_dload); end
      checks++; if (bus.iload !== e_iload) begin errors++; $display("FAIL rnd_iload cyc%0d: got %h want %h", cyc, bus.iload, e_iload); end

      for (int c = 0; c < CPUS; c++) begin
        d_ack[c] = !bus.dwait[c];
        i_ack[c] = !bus.iwait[c];
      end

      // Advance the model to the state after the coming rising edge.
      if (m_active) begin
        if (!held) begin
          m_active = 1'b0;
        end else if (acc) begin
          m_done = m_done + 1;
          if (!m_data || m_done == BURST) m_active = 1'b0;
        end
      end else begin
        sel = pick(bus.dREN | bus.dWEN, m_dlast);
        if (sel >= 0) begin
          m_active = 1'b1; m_data = 1'b1; m_core = sel;
          m_write = bus.dWEN[sel]; m_done = 0; m_dlast = sel;
        end else begin
          sel = pick(bus.iREN, m_ilast);
          if (sel >= 0) begin
            m_active = 1'b1; m_data = 1'b0; m_core = sel;
            m_write = 1'b0; m_done = 0; m_ilast = sel;
          end
        end
      end
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_fetch();
    test_data_priority();
    test_back_to_back();
    test_write_priority();
    test_busy_stall();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
